// File: rtl/press_classifier_pkg.sv
// press_classifier_pkg: shared state encodings and tick divider constants for the button unit
package press_classifier_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam int SIM_DIV   = 32;
    localparam int SIM_DIV_W = 5;
    localparam int HW_DIV    = 100000;
    localparam int HW_DIV_W  = 17;

endpackage

// File: rtl/press_classifier_counter_n.sv
// counter_n: free-running modulo-N divider emitting a one-clk tick every N clocks
module counter_n #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == W'(N - 1));
    assign cnt_d  = tick_o ? '0 : cnt_q + W'(1);

    // wrap the count at N-1 so the tick recurs every N clocks
    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end

endmodule

// File: rtl/press_classifier.sv
// press_classifier: turns a debounced button level into click / double-click / long-press pulses
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter bit sim      = 1'b0,
    parameter int LONG_MS  = 1000,
    parameter int DBL_MS   = 300,
    parameter int CNT_BITS = 11
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic click,
    output logic dclick,
    output logic lpress,
    output logic busy
);

    localparam int DIV_N = sim ? SIM_DIV : HW_DIV;
    localparam int DIV_W = sim ? SIM_DIV_W : HW_DIV_W;
    localparam logic [CNT_BITS-1:0] LONG_C = CNT_BITS'(LONG_MS);
    localparam logic [CNT_BITS-1:0] DBL_C  = CNT_BITS'(DBL_MS);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] ms_q, ms_d;
    logic                in_d_q;
    logic                click_q, click_d;
    logic                dclick_q, dclick_d;
    logic                lpress_q, lpress_d;
    logic                busy_q;
    logic                tick;
    logic                rise;
    logic                fall;

    counter_n #(.N(DIV_N), .W(DIV_W)) u_div (
        .clk    (clk),
        .reset  (reset),
        .tick_o (tick)
    );

    assign rise = in & ~in_d_q;
    assign fall = ~in & in_d_q;

    // gesture FSM: edges take priority over window expiry in every state
    always_comb begin
        state_d  = state_q;
        click_d  = 1'b0;
        dclick_d = 1'b0;
        lpress_d = 1'b0;
        case (state_q)
            IDLE:   if (rise) state_d = PRESS1;
            PRESS1: if (fall) state_d = WAIT2;
                    else if (ms_q == LONG_C) begin
                        state_d  = HOLD;
                        lpress_d = 1'b1;
                    end
            WAIT2:  if (rise) state_d = PRESS2;
                    else if (ms_q == DBL_C) begin
                        state_d = IDLE;
                        click_d = 1'b1;
                    end
            PRESS2: if (fall) begin
                        state_d  = IDLE;
                        dclick_d = 1'b1;
                    end else if (ms_q == LONG_C) begin
                        state_d  = HOLD;
                        dclick_d = 1'b1;
                    end
            HOLD:   if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ms window counter restarts on every state change and saturates at all-ones
    assign ms_d = (state_d != state_q) ? '0 :
                  (tick && ms_q != '1) ? ms_q + CNT_BITS'(1) : ms_q;

    // state, edge history, window counter and registered event outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            in_d_q   <= 1'b1;
            click_q  <= 1'b0;
            dclick_q <= 1'b0;
            lpress_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            in_d_q   <= in;
            click_q  <= click_d;
            dclick_q <= dclick_d;
            lpress_q <= lpress_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign click  = click_q;
    assign dclick = dclick_q;
    assign lpress = lpress_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: scripted and random gestures checked against a timestamp-based gesture model
module tb_press_classifier;

    localparam int MS    = 32;
    localparam int LMS   = 10;
    localparam int DMS   = 4;
    localparam int P_IDLE = 0, P_P1 = 1, P_W2 = 2, P_P2 = 3, P_HOLD = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_in = 1'b0;
    logic click, dclick, lpress, busy;

    int checks = 0;
    int errors = 0;
    int tcyc = 0;
    int n_click, n_dclick, n_lpress;
    int t_click, t_dclick, t_lpress;

    int   ph, e_edge, i_edge;
    logic prev;
    logic mc, md, ml, mb;

    press_classifier #(.sim(1'b1), .LONG_MS(LMS), .DBL_MS(DMS), .CNT_BITS(11)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (b_in),
        .click  (click),
        .dclick (dclick),
        .lpress (lpress),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (step %0d)", name, got, exp, tcyc);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got %0d expected range %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Model: elapsed ms in a phase is the number of divider ticks between entry edge and now,
    // where ticks fall on edges 31, 63, ... counted from the first edge after reset.
    task automatic model_step(input logic r, input logic v);
        int ms, nph;
        logic rise, fall;
        if (r) begin
            ph = P_IDLE; e_edge = 0; i_edge = 0; prev = 1'b1;
            {mc, md, ml, mb} = 4'b0;
        end else begin
            ms   = i_edge / MS - (e_edge + 1) / MS;
            rise = v & ~prev;
            fall = ~v & prev;
            prev = v;
            nph  = ph;
            {mc, md, ml} = 3'b0;
            if (ph == P_IDLE && rise) nph = P_P1;
            else if (ph == P_P1) begin
                if (fall) nph = P_W2;
                else if (ms == LMS) begin nph = P_HOLD; ml = 1'b1; end
            end else if (ph == P_W2) begin
                if (rise) nph = P_P2;
                else if (ms == DMS) begin nph = P_IDLE; mc = 1'b1; end
            end else if (ph == P_P2) begin
                if (fall || ms == LMS) begin nph = fall ? P_IDLE : P_HOLD; md = 1'b1; end
            end else if (ph == P_HOLD && fall) nph = P_IDLE;
            if (nph != ph) e_edge = i_edge;
            ph = nph;
            mb = (ph != P_IDLE);
            i_edge++;
        end
    endtask

    task automatic cyc(input logic r, input logic v);
        tcyc++;
        reset = r;
        b_in  = v;
        model_step(r, v);
        @(negedge clk);
        chk("click", int'(click), int'(mc));
        chk("dclick", int'(dclick), int'(md));
        chk("lpress", int'(lpress), int'(ml));
        chk("busy", int'(busy), int'(mb));
        if (click) begin n_click++; t_click = tcyc; end
        if (dclick) begin n_dclick++; t_dclick = tcyc; end
        if (lpress) begin n_lpress++; t_lpress = tcyc; end
    endtask

    task automatic run(input logic r, input logic v, input int n);
        for (int k = 0; k < n; k++) cyc(r, v);
    endtask

    task automatic clr();
        n_click = 0; n_dclick = 0; n_lpress = 0;
        t_click = 0; t_dclick = 0; t_lpress = 0;
    endtask

    initial begin
        int t0;
        clr();
        @(negedge clk);
        run(1'b1, 1'b0, 3);
        chk("reset_busy", int'(busy), 0);
        chk("reset_events", int'({click, dclick, lpress}), 0);

        // 1: single click
        clr();
        run(1'b0, 1'b0, 5);
        run(1'b0, 1'b1, 3 * MS);
        t0 = tcyc + 1;
        run(1'b0, 1'b0, 6 * MS);
        chk("s1_clicks", n_click, 1);
        chk("s1_others", n_dclick + n_lpress, 0);
        chk_rng("s1_click_latency", t_click - t0, 96, 130);

        // 2: double click
        clr();
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, 2 * MS);
        run(1'b0, 1'b1, 2 * MS);
        t0 = tcyc + 1;
        run(1'b0, 1'b0, 6 * MS);
        chk("s2_dclicks", n_dclick, 1);
        chk("s2_others", n_click + n_lpress, 0);
        chk("s2_dclick_latency", t_dclick - t0, 0);

        // 3: long press
        clr();
        t0 = tcyc + 1;
        run(1'b0, 1'b1, 15 * MS);
        chk("s3_lpress", n_lpress, 1);
        chk_rng("s3_lpress_latency", t_lpress - t0, 286, 322);
        chk("s3_busy_held", int'(busy), 1);
        cyc(1'b0, 1'b0);
        chk("s3_busy_after_release", int'(busy), 0);
        run(1'b0, 1'b0, 6 * MS);
        chk("s3_others", n_click + n_dclick + n_lpress, 1);

        // 4: gap too long -> two clicks
        clr();
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, 5 * MS);
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, 6 * MS);
        chk("s4_clicks", n_click, 2);
        chk("s4_dclicks", n_dclick, 0);

        // 5: held through reset
        clr();
        run(1'b1, 1'b1, 3);
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, 6 * MS);
        chk("s5_no_events", n_click + n_dclick + n_lpress, 0);
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, 6 * MS);
        chk("s5_click_after", n_click, 1);

        // 6: reset while waiting for a second press
        clr();
        run(1'b0, 1'b1, 2 * MS);
        run(1'b0, 1'b0, MS);
        cyc(1'b1, 1'b0);
        chk("s6_busy_after_reset", int'(busy), 0);
        run(1'b0, 1'b0, 6 * MS);
        chk("s6_no_click", n_click, 0);

        // random gestures, occasional resets
        for (int g = 0; g < 40; g++) begin
            if ($urandom_range(0, 9) == 0) run(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            run(1'b0, 1'b1, $urandom_range(1, 14 * MS));
            run(1'b0, 1'b0, $urandom_range(1, 7 * MS));
        end
        run(1'b0, 1'b0, 6 * MS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
